// File: rtl/pipe_ctrl_pkg.sv
// Types and constants shared by the pipeline stall/flush control slice
// and the pipeline registers it drives.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } md_state_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam logic [4:0]  REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: the instruction in ID reads a register that the
// load currently in EX has not yet written back.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       load_use
);

  logic rs1_hit_s;
  logic rs2_hit_s;

  // Match each used source against the load destination; x0 never hazards
  always_comb begin
    rs1_hit_s = id_use_rs1 & (id_rs1 == ex_rd);
    rs2_hit_s = id_use_rs2 & (id_rs2 == ex_rd);
    load_use  = ex_mem_read & (ex_rd != REG_ZERO) & (rs1_hit_s | rs2_hit_s);
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: prioritises
// memory wait, mul/div occupancy, load-use and branch redirects.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_md_start,
  input  logic             md_done,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned     MDC_W   = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [MDC_W-1:0] MD_LAST = MDC_W'(MD_TIMEOUT - 1);

  md_state_e        state_r;
  logic             done_pend_r;
  logic [MDC_W-1:0] md_cnt_r;
  logic             md_timeout_r;
  logic [CNT_W-1:0] stall_cnt_r;

  logic mem_wait_s, load_use_s, md_done_any_s, md_expire_s, md_exit_s, md_enter_s;
  logic pc_st_s, if_id_st_s, id_ex_st_s, ex_mem_st_s;
  logic if_id_fl_s, id_ex_fl_s, ex_mem_fl_s, mem_wb_fl_s;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use_s)
  );

  // Hazard qualifiers and mul/div entry/exit decisions for this cycle
  always_comb begin
    mem_wait_s    = mem_req & ~mem_ready;
    md_done_any_s = md_done | done_pend_r;
    md_expire_s   = (md_cnt_r == MD_LAST) & ~md_done_any_s;
    md_exit_s     = (state_r == MD_WAIT) & ~mem_wait_s
                    & (md_done_any_s | (md_cnt_r == MD_LAST));
    md_enter_s    = (state_r == RUN) & ex_md_start & ~mem_wait_s;
  end

  // Prioritised stall/flush decode; the first matching hazard owns the pipe
  always_comb begin
    pc_st_s     = 1'b0;
    if_id_st_s  = 1'b0;
    id_ex_st_s  = 1'b0;
    ex_mem_st_s = 1'b0;
    if_id_fl_s  = 1'b0;
    id_ex_fl_s  = 1'b0;
    ex_mem_fl_s = 1'b0;
    mem_wb_fl_s = 1'b0;
    if (rst) begin
      if_id_fl_s  = 1'b1;
      id_ex_fl_s  = 1'b1;
      ex_mem_fl_s = 1'b1;
      mem_wb_fl_s = 1'b1;
    end else if (mem_wait_s) begin
      pc_st_s     = 1'b1;
      if_id_st_s  = 1'b1;
      id_ex_st_s  = 1'b1;
      ex_mem_st_s = 1'b1;
      mem_wb_fl_s = 1'b1;
    end else if (md_enter_s || ((state_r == MD_WAIT) && !md_exit_s)) begin
      pc_st_s     = 1'b1;
      if_id_st_s  = 1'b1;
      id_ex_st_s  = 1'b1;
      ex_mem_fl_s = 1'b1;
    end else if (ex_branch_taken) begin
      // EX advances here, so the redirect kills both younger instructions
      if_id_fl_s  = 1'b1;
      id_ex_fl_s  = 1'b1;
    end else if ((state_r == RUN) && load_use_s) begin
      pc_st_s     = 1'b1;
      if_id_st_s  = 1'b1;
      id_ex_fl_s  = 1'b1;
    end else begin
      pc_st_s     = 1'b0;
    end
  end

  assign pc_stall     = pc_st_s;
  assign if_id_stall  = if_id_st_s  & ~if_id_fl_s;
  assign id_ex_stall  = id_ex_st_s  & ~id_ex_fl_s;
  assign ex_mem_stall = ex_mem_st_s & ~ex_mem_fl_s;
  assign if_id_flush  = if_id_fl_s;
  assign id_ex_flush  = id_ex_fl_s;
  assign ex_mem_flush = ex_mem_fl_s;
  assign mem_wb_flush = mem_wb_fl_s;
  assign md_timeout   = md_timeout_r;
  assign stall_cnt    = stall_cnt_r;

  // Mul/div FSM, watchdog, pending-done latch and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= RUN;
      done_pend_r  <= 1'b0;
      md_cnt_r     <= '0;
      md_timeout_r <= 1'b0;
      stall_cnt_r  <= '0;
    end else begin
      if (pc_st_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      case (state_r)
        RUN: begin
          if (md_enter_s) begin
            state_r     <= MD_WAIT;
            md_cnt_r    <= '0;
            done_pend_r <= 1'b0;
          end
        end
        MD_WAIT: begin
          if (md_exit_s) begin
            state_r     <= RUN;
            done_pend_r <= 1'b0;
            if (md_expire_s) begin
              md_timeout_r <= 1'b1;
            end
          end else begin
            // Only a memory wait can block an exit, so a done here must be remembered
            if (md_done) begin
              done_pend_r <= 1'b1;
            end
            if (md_cnt_r != MD_LAST) begin
              md_cnt_r <= md_cnt_r + MDC_W'(1);
            end
          end
        end
        default: begin
          state_r     <= RUN;
          done_pend_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stall/flush sequencer for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB). It merges four hazard sources: data-memory wait, multi-cycle mul/div in EX, load-use, and taken branch/jump. It produces per-stage hold and bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It replaces the ad-hoc per-register stall logic with one prioritised FSM, plus a mul/div watchdog and a saturating stall-cycle counter.

## Interface
- MD_TIMEOUT, 64: max cycles in MD_WAIT before forced release.
- CNT_W, 32: width of stall-cycle counter.
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs1, id_rs2  in  5  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  EX resolved a taken branch/jump (redirect PC).
- ex_md_start  in  1  EX holds a mul/div op; level, held while EX is frozen.
- md_done  in  1  one-cycle pulse from the mul/div unit, result valid.
- mem_req  in  1  MEM stage has an active data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1  hold the register.
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1  load a bubble (NOP).
- md_timeout  out  1  sticky; the watchdog fired.
- stall_cnt  out  CNT_W  cycles with pc_stall=1, saturating at all-ones.

## Operation
- mem_wait = mem_req & ~mem_ready (combinational). Highest priority.
  - Asserts pc/if_id/id_ex/ex_mem stall and mem_wb_flush.
  - Forces all other flushes to 0.
- FSM states: RUN, MD_WAIT.
  - RUN→MD_WAIT: ex_md_start & ~mem_wait. In that same cycle the MD_WAIT outputs already apply.
  - MD_WAIT→RUN: (md_done | done_pend) & ~mem_wait, or the timeout.
  - done_pend: set by md_done while mem_wait=1; cleared on MD_WAIT exit.
- MD_WAIT outputs (when no mem_wait):
  - Stall PC, IF/ID and ID/EX.
  - Assert ex_mem_flush.
  - On the exit cycle: no stall, no flush. EX/MEM captures the result.
- Load-use, in RUN with no mem_wait and no md_start:
  - Condition: ex_mem_read & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - Action: stall PC and IF/ID, assert id_ex_flush for exactly one cycle.
- Branch flush: ex_branch_taken asserts if_id_flush and id_ex_flush only in cycles where EX advances.
  - EX advances when there is no mem_wait and either no md_start, or the MD_WAIT exit cycle.
  - Branch flush overrides load-use: no stall, both flushes.
- A flush on a register overrides a stall on the same register. The two are never both 1 on the outputs.
- Watchdog:
  - md_cnt clears on MD_WAIT entry and increments each MD_WAIT cycle.
  - At md_cnt==MD_TIMEOUT-1 without done: set md_timeout and return to RUN. EX/MEM captures whatever the unit outputs.
- stall_cnt: +1 each cycle pc_stall=1; holds at 2^CNT_W-1.

## Timing
- Stall and flush outputs are combinational from inputs and current state; same-cycle response. FSM, done_pend, md_cnt, md_timeout and stall_cnt are registered.
- Behaviour while rst=1:
  - All stalls are 0.
  - All four flushes are 1.
  - md_timeout=0 and stall_cnt=0.
  - State=RUN, done_pend=0, md_cnt=0.
- After rst deasserts, outputs follow the rules above; no extra settling cycles.
- Load-use costs 1 bubble. Mul/div costs N+1 cycles in EX when md_done arrives N cycles after entry. Mem wait costs the number of ~mem_ready cycles.
- If rst is asserted mid-MD_WAIT, the block returns to RUN next edge; done_pend is dropped.
- If md_done and mem_wait coincide, done_pend=1 and the exit happens on the first cycle with mem_wait=0.
- If ex_md_start and mem_wait coincide, MD_WAIT entry is deferred until mem_wait clears.

## Structure
- Shared package pipe_ctrl_pkg:
  - State enum {RUN, MD_WAIT}.
  - NOP-bubble encoding constant (0x00000013), shared with the pipeline registers.
  - REG_ZERO constant.
- One natural sub-module: hazard_detect, a combinational load-use comparator. Everything else lives in pipeline_stall_ctrl.

## Test plan
- lw x5 in EX, add x6,x5,x1 in ID → exactly one cycle of pc_stall=if_id_stall=id_ex_flush=1, then flow; stall_cnt=1.
- ex_md_start=1, md_done pulses 4 cycles after entry → 4 cycles of stall with ex_mem_flush, 5th cycle all 0, state RUN.
- In MD_WAIT, mem_req=1/mem_ready=0 for 3 cycles with md_done in the 2nd → mem_wb_flush for 3 cycles, then MD exit on the next cycle with no further md_done.
- ex_branch_taken=1 while ex_mem_read hazard present → if_id_flush=id_ex_flush=1, no stall; the same branch held during a 2-cycle mem_wait → flushes appear only in the release cycle.
- md_done never arrives, MD_TIMEOUT=8 → release after 8 MD_WAIT cycles, md_timeout=1 and held until rst.
- rst asserted mid-MD_WAIT with stall_cnt=20 → next cycle RUN, stall_cnt=0, all flushes 1 during rst; ex_rd=0 load hazard → no stall.
